// File: rtl/pipelined_control_unit.sv
// Registered decode control unit: decodes opcode/funct3 into a control bundle held in a
// single-entry valid/ready output register, and tracks one outstanding d-cache access.
module pipelined_control_unit #(
  parameter int ALU_OP_WIDTH = 2,
  parameter int MEM_TIMEOUT  = 16,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [6:0]              opcode,
  input  logic [2:0]              funct3,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  input  logic                    mem_done,
  output logic                    d_cache_access,
  output logic                    d_cache_op,
  output logic                    branch,
  output logic                    reg_write,
  output logic [ALU_OP_WIDTH-1:0] alu_op,
  output logic                    alu_src,
  output logic                    is_imm,
  output logic                    is_byte_op,
  output logic                    illegal,
  output logic                    busy,
  output logic                    mem_timeout,
  output logic [CNT_WIDTH-1:0]    issued_count
);

  // Handshake contract: a transfer happens on an edge where valid && ready are both high.
  // in_ready never depends on in_valid; out_valid, once high, holds the bundle unchanged
  // until out_ready is seen (or flush/rst kills it).

  localparam int TIMER_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(MEM_TIMEOUT - 1);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JUMP   = 7'b1100111;

  localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD    = ALU_OP_WIDTH'(2'b00);
  localparam logic [ALU_OP_WIDTH-1:0] ALU_BRANCH = ALU_OP_WIDTH'(2'b01);
  localparam logic [ALU_OP_WIDTH-1:0] ALU_RTYPE  = ALU_OP_WIDTH'(2'b10);
  localparam logic [ALU_OP_WIDTH-1:0] ALU_JUMP   = ALU_OP_WIDTH'(2'b11);

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  state_t               state;
  logic [TIMER_W-1:0]   timer;

  logic                    dec_access;
  logic                    dec_op;
  logic                    dec_branch;
  logic                    dec_reg_write;
  logic [ALU_OP_WIDTH-1:0] dec_alu_op;
  logic                    dec_alu_src;
  logic                    dec_is_imm;
  logic                    dec_is_byte_op;
  logic                    dec_illegal;

  logic accept;
  logic consume;

  always_comb begin
    dec_access     = 1'b0;
    dec_op         = 1'b0;
    dec_branch     = 1'b0;
    dec_reg_write  = 1'b0;
    dec_alu_op     = ALU_ADD;
    dec_alu_src    = 1'b0;
    dec_is_imm     = 1'b0;
    dec_is_byte_op = 1'b0;
    dec_illegal    = 1'b0;
    case (opcode)
      OP_R: begin
        dec_reg_write = 1'b1;
        dec_alu_op    = ALU_RTYPE;
      end
      OP_LOAD: begin
        dec_reg_write = 1'b1;
        dec_alu_src   = 1'b1;
        // funct3=001 is LDI: the immediate is the result, no d-cache traffic.
        if (funct3 == 3'b001) begin
          dec_is_imm = 1'b1;
        end else begin
          dec_access     = 1'b1;
          dec_op         = 1'b1;
          dec_is_byte_op = (funct3 == 3'b000);
        end
      end
      OP_STORE: begin
        dec_access     = 1'b1;
        dec_alu_src    = 1'b1;
        dec_is_byte_op = (funct3 == 3'b000);
      end
      OP_BRANCH: begin
        dec_branch = 1'b1;
        dec_alu_op = ALU_BRANCH;
      end
      OP_JUMP: begin
        dec_branch = 1'b1;
        dec_alu_op = ALU_JUMP;
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // Held low during reset so no instruction is taken while the unit is being cleared.
  assign in_ready = !rst && (state == RUN) && (!out_valid || out_ready) && !flush;
  assign accept   = in_valid && in_ready;
  assign consume  = out_valid && out_ready;
  assign busy     = (state == MEM_WAIT);

  always_ff @(posedge clk) begin
    if (rst || flush || (consume && !accept)) begin
      out_valid      <= 1'b0;
      d_cache_access <= 1'b0;
      d_cache_op     <= 1'b0;
      branch         <= 1'b0;
      reg_write      <= 1'b0;
      alu_op         <= ALU_ADD;
      alu_src        <= 1'b0;
      is_imm         <= 1'b0;
      is_byte_op     <= 1'b0;
      illegal        <= 1'b0;
    end else if (accept) begin
      out_valid      <= 1'b1;
      d_cache_access <= dec_access;
      d_cache_op     <= dec_op;
      branch         <= dec_branch;
      reg_write      <= dec_reg_write;
      alu_op         <= dec_alu_op;
      alu_src        <= dec_alu_src;
      is_imm         <= dec_is_imm;
      is_byte_op     <= dec_is_byte_op;
      illegal        <= dec_illegal;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issued_count <= '0;
    end else if (consume) begin
      issued_count <= issued_count + CNT_WIDTH'(1);
    end
  end

  // A consumed access cannot be recalled, so flush has no say over the wait state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      timer       <= '0;
      mem_timeout <= 1'b0;
    end else begin
      mem_timeout <= 1'b0;
      case (state)
        RUN: begin
          if (consume && d_cache_access) begin
            state <= MEM_WAIT;
            timer <= '0;
          end
        end
        MEM_WAIT: begin
          if (mem_done) begin
            state <= RUN;
            timer <= '0;
          end else if (timer == TIMER_LAST) begin
            state       <= RUN;
            timer       <= '0;
            mem_timeout <= 1'b1;
          end else begin
            timer <= timer + TIMER_W'(1);
          end
        end
        default: begin
          state <= RUN;
          timer <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Bench for pipelined_control_unit: directed scenarios then randomized traffic, all
// compared cycle by cycle against a transaction-level reference model.
module tb_pipelined_control_unit;

  localparam int AW = 2;
  localparam int MT = 4;
  localparam int CW = 2;

  localparam logic [6:0] R_OP   = 7'b0110011;
  localparam logic [6:0] LD_OP  = 7'b0000011;
  localparam logic [6:0] ST_OP  = 7'b0100011;
  localparam logic [6:0] BR_OP  = 7'b1100011;
  localparam logic [6:0] JMP_OP = 7'b1100111;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [6:0]    opcode;
  logic [2:0]    funct3;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic          mem_done;
  logic          d_cache_access;
  logic          d_cache_op;
  logic          branch;
  logic          reg_write;
  logic [AW-1:0] alu_op;
  logic          alu_src;
  logic          is_imm;
  logic          is_byte_op;
  logic          illegal;
  logic          busy;
  logic          mem_timeout;
  logic [CW-1:0] issued_count;

  pipelined_control_unit #(
    .ALU_OP_WIDTH(AW),
    .MEM_TIMEOUT (MT),
    .CNT_WIDTH   (CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .opcode        (opcode),
    .funct3        (funct3),
    .flush         (flush),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .mem_done      (mem_done),
    .d_cache_access(d_cache_access),
    .d_cache_op    (d_cache_op),
    .branch        (branch),
    .reg_write     (reg_write),
    .alu_op        (alu_op),
    .alu_src       (alu_src),
    .is_imm        (is_imm),
    .is_byte_op    (is_byte_op),
    .illegal       (illegal),
    .busy          (busy),
    .mem_timeout   (mem_timeout),
    .issued_count  (issued_count)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [15:0] exp_q[$];

  // Reference model: a bundle slot, an outstanding-access flag with its start edge.
  bit         m_valid;
  logic [9:0] m_bundle;   // {access, op, branch, reg_write, alu_op[1:0], alu_src, is_imm, is_byte, illegal}
  bit         m_wait;
  int         m_entry;
  bit         m_pulse;
  int         m_count;
  int         edge_no;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [9:0] ref_decode(input logic [6:0] op, input logic [2:0] f3);
    logic byte_sz;
    byte_sz = (f3 == 3'b000);
    case (op)
      R_OP:   return 10'b0001_10_0000;
      LD_OP:  return (f3 == 3'b001) ? 10'b0001_00_1100 : {8'b1101_00_10, byte_sz, 1'b0};
      ST_OP:  return {8'b1000_00_10, byte_sz, 1'b0};
      BR_OP:  return 10'b0010_01_0000;
      JMP_OP: return 10'b0010_11_0000;
      default: return 10'b0000_00_0001;
    endcase
  endfunction

  function automatic bit ref_in_ready(input logic fl, input logic ordy, input logic r);
    return !r && !m_wait && (!m_valid || ordy) && !fl;
  endfunction

  task automatic model_edge(input logic iv, input logic [6:0] op, input logic [2:0] f3,
                            input logic fl, input logic ordy, input logic md, input logic r);
    bit acc, cons;
    edge_no++;
    if (r) begin
      m_valid = 0; m_bundle = '0; m_wait = 0; m_pulse = 0; m_count = 0;
    end else begin
      acc  = iv && ref_in_ready(fl, ordy, r);
      cons = m_valid && ordy;
      m_pulse = 0;
      if (m_wait) begin
        if (md) m_wait = 0;
        else if (edge_no - m_entry == MT) begin
          m_wait  = 0;
          m_pulse = 1;
        end
      end else if (cons && m_bundle[9]) begin
        m_wait  = 1;
        m_entry = edge_no;
      end
      if (cons) m_count = (m_count + 1) % (1 << CW);
      if (fl) begin
        m_valid = 0; m_bundle = '0;
      end else if (acc) begin
        m_valid = 1; m_bundle = ref_decode(op, f3);
      end else if (cons) begin
        m_valid = 0; m_bundle = '0;
      end
    end
    exp_q.push_back({1'b0, m_valid, m_bundle, m_wait, m_pulse, CW'(m_count)});
  endtask

  task automatic check_outputs();
    logic [15:0] e;
    if (exp_q.size() == 0) begin
      check("exp_q_empty", 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    check("out_valid", out_valid, e[14]);
    check("bundle", {d_cache_access, d_cache_op, branch, reg_write, alu_op, alu_src,
                     is_imm, is_byte_op, illegal}, e[13:4]);
    check("busy", busy, e[3]);
    check("mem_timeout", mem_timeout, e[2]);
    check("issued_count", issued_count, e[1:0]);
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic step(input logic iv, input logic [6:0] op, input logic [2:0] f3,
                      input logic fl, input logic ordy, input logic md, input logic r);
    in_valid = iv; opcode = op; funct3 = f3; flush = fl;
    out_ready = ordy; mem_done = md; rst = r;
    #1;
    check("in_ready", in_ready, ref_in_ready(fl, ordy, r));
    model_edge(iv, op, f3, fl, ordy, md, r);
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input logic md);
    step(1'b0, 7'd0, 3'd0, 1'b0, 1'b1, md, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int pulses;
    int saved;
    logic [6:0] op;
    m_valid = 0; m_bundle = '0; m_wait = 0; m_entry = 0; m_pulse = 0; m_count = 0; edge_no = 0;

    step(1'b0, 7'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 7'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("rst_out_valid", out_valid, 0);
    check("rst_count", issued_count, 0);
    check("rst_in_ready", in_ready, 0);

    // R-type, latency 1, then consumed
    step(1'b1, R_OP, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("r_reg_write", reg_write, 1);
    check("r_alu_op", alu_op, 2'b10);
    idle(1'b0);
    check("r_count", issued_count, 1);

    // byte store, then mem_done on the third wait cycle
    step(1'b1, ST_OP, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
    check("st_byte", is_byte_op, 1);
    check("st_op", d_cache_op, 0);
    idle(1'b0);
    check("st_busy", busy, 1);
    idle(1'b0);
    idle(1'b0);
    idle(1'b1);
    check("st_done_busy", busy, 0);
    check("st_done_in_ready", in_ready, 1);

    // word load with no mem_done: single timeout pulse MT cycles after entry
    step(1'b1, LD_OP, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1'b0);
    pulses = 0;
    for (int i = 0; i < MT; i++) begin
      idle(1'b0);
      if (mem_timeout) pulses++;
    end
    check("ld_timeout_last", mem_timeout, 1);
    check("ld_pulses", pulses, 1);
    check("ld_busy_after", busy, 0);
    idle(1'b0);
    check("ld_pulse_gone", mem_timeout, 0);

    // LDI, then illegal opcode accepted back to back
    step(1'b1, LD_OP, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0);
    check("ldi_imm", is_imm, 1);
    check("ldi_access", d_cache_access, 0);
    step(1'b1, 7'b1111111, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("ill_flag", illegal, 1);
    check("ldi_no_wait", busy, 0);
    idle(1'b0);

    // stall for 5 cycles, then flush
    step(1'b1, R_OP, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, BR_OP, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("stall_in_ready", in_ready, 0);
    check("stall_alu_op", alu_op, 2'b10);
    saved = issued_count;
    step(1'b1, BR_OP, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("flush_valid", out_valid, 0);
    check("flush_count", issued_count, saved);

    // counter wrap: 5 consumes on a 2-bit counter
    step(1'b0, 7'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, R_OP, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1'b0);
    check("wrap_count", issued_count, 1);

    // reset during MEM_WAIT
    step(1'b1, ST_OP, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b0);
    check("pre_rst_busy", busy, 1);
    step(1'b0, 7'd0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("rst_wait_busy", busy, 0);
    check("rst_wait_count", issued_count, 0);
    check("rst_wait_valid", out_valid, 0);

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      case ($urandom_range(0, 6))
        0: op = R_OP;
        1: op = LD_OP;
        2: op = ST_OP;
        3: op = BR_OP;
        4: op = JMP_OP;
        5: op = LD_OP;
        default: op = 7'($urandom);
      endcase
      step(1'($urandom_range(0, 3) != 0), op, 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 9) < 7),
           1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 99) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipelined_control_unit.md
Name: pipelined_control_unit

Overview:
Registered, handshaked successor to the combinational decode control unit. Decodes opcode/funct3 into control bundles and holds them in a single-entry ID/EX output register with valid/ready flow control. Tracks outstanding d-cache operations with a wait FSM and a timeout. Flags illegal opcodes and counts issued instructions. Sits between the fetch/decode register and the execute stage.

Parameters:
ALU_OP_WIDTH, 2, width of alu_op encoding
MEM_TIMEOUT, 16, max cycles in MEM_WAIT before abort (>=1)
CNT_WIDTH, 16, width of issued-instruction counter (wraps)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  decode slot holds an instruction
in_ready  out  1  unit accepts opcode/funct3 this cycle
opcode  in  7  instruction opcode
funct3  in  3  instruction funct3
flush  in  1  kill the registered, not-yet-consumed bundle (branch mispredict)
out_valid  out  1  control bundle valid
out_ready  in  1  execute stage consumes the bundle
mem_done  in  1  d-cache completed the outstanding access
d_cache_access  out  1  bundle performs a memory access
d_cache_op  out  1  1=read (load), 0=write (store)
branch  out  1  branch/jump
reg_write  out  1  writes the register file
alu_op  out  ALU_OP_WIDTH  00 add/mem, 01 branch, 10 R-type, 11 jump
alu_src  out  1  ALU operand B = immediate
is_imm  out  1  LDI (load immediate)
is_byte_op  out  1  byte-sized load/store
illegal  out  1  unknown opcode in bundle
busy  out  1  state==MEM_WAIT
mem_timeout  out  1  one-cycle pulse on MEM_WAIT abort
issued_count  out  CNT_WIDTH  bundles consumed since reset

Behaviour:
- Reset: all outputs 0, issued_count 0, state RUN, timer 0.
- Decode table (fields not listed = 0):
  - 0110011 R: reg_write=1, alu_op=10.
  - 0000011 load: reg_write=1, alu_src=1, alu_op=00. funct3=001 gives LDI: is_imm=1, access=0. Any other funct3: access=1, op=1, is_byte_op=(funct3==000).
  - 0100011 store: access=1, op=0, alu_src=1, alu_op=00, is_byte_op=(funct3==000).
  - 1100011 branch: branch=1, alu_op=01.
  - 1100111 jump: branch=1, alu_op=11.
  - Any other opcode: illegal=1, all others 0.
- Handshake:
  - in_ready = (state==RUN) && (!out_valid || out_ready) && !flush.
  - Accept = in_valid && in_ready. On accept the decoded bundle is registered and out_valid=1 next cycle (latency 1).
  - Consume = out_valid && out_ready. If consume with no accept, out_valid=0 next cycle.
  - Simultaneous consume+accept keeps out_valid=1 with the new bundle: back-to-back throughput 1/cycle.
  - Outputs stay stable while out_valid && !out_ready.
- Flush:
  - Next cycle: out_valid=0, bundle fields cleared, no accept that cycle.
  - A bundle consumed in the flush cycle still counts and can enter MEM_WAIT.
  - Flush never leaves MEM_WAIT; the issued access cannot be cancelled.
- FSM:
  - RUN -> MEM_WAIT when the consumed bundle has d_cache_access=1; timer cleared.
  - MEM_WAIT: in_ready=0, timer increments each cycle.
  - mem_done returns to RUN next cycle.
  - If timer reaches MEM_TIMEOUT-1 without mem_done: return to RUN and pulse mem_timeout for 1 cycle.
  - mem_done and timeout in the same cycle: mem_done wins, no pulse.
  - mem_done while in RUN is ignored.
- issued_count increments by 1 per consume and wraps modulo 2^CNT_WIDTH.
- rst mid-MEM_WAIT or mid-stall: full return to reset state next edge.

Test Plan:
- R-type 0110011, out_ready=1 -> next cycle out_valid=1, reg_write=1, alu_op=10, others 0; issued_count=1.
- Store 0100011/funct3=000 consumed -> is_byte_op=1, op=0; busy=1, in_ready=0. mem_done after 3 cycles -> RUN and in_ready=1 the next cycle.
- Load funct3=010 with no mem_done, MEM_TIMEOUT=4 -> mem_timeout pulses exactly once 4 cycles after entry, then busy=0.
- LDI funct3=001 -> is_imm=1, d_cache_access=0, no MEM_WAIT. Then opcode 1111111 -> illegal=1.
- Hold out_ready=0 for 5 cycles with in_valid=1 -> bundle stable, in_ready=0. Assert flush -> out_valid=0 next cycle, count unchanged.
- CNT_WIDTH=2, 5 consumes -> issued_count=1. Assert rst during MEM_WAIT -> all outputs 0 next cycle.
